// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator stage: opcodes, FSM state encoding and default width.
package alu_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Ops that update the accumulator and produce a result.
    function automatic logic is_commit(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_AND) || (op == OP_NAND) || (op == OP_CLEAR);
    endfunction

    // Opcodes 5-7 carry no operation and raise err when accepted.
    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_CLEAR;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Zero/negative status of a candidate accumulator value; the parent registers them with the data.
module alu_flag_gen #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             neg
);
    assign zero = (value == '0);
    assign neg  = value[WIDTH-1];
endmodule

// File: rtl/and_gate.sv
// Combinational bitwise AND of two WIDTH-bit words.
module and_gate #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a & b;
endmodule

// File: rtl/nand_gate.sv
// Combinational bitwise NAND of two WIDTH-bit words.
module nand_gate #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = ~(a & b);
endmodule

// File: rtl/alu_acc_stage.sv
// Registered logic accumulator with valid/ready on both sides (1 op/cycle when unstalled).
// Define ALU_ACC_OP_COUNT_EN to add the committed-op counter output op_count.
module alu_acc_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             err
`ifdef ALU_ACC_OP_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] op_count
`endif
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("alu_acc_stage: CNT_WIDTH must be at least 1");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_p1;
    logic [WIDTH-1:0]  and_y, nand_y, next_acc;
    logic              zero_d, neg_d;
    logic              accept, commit, reserved, consume;

    assign accept   = in_valid && in_ready;
    assign commit   = accept && is_commit(opcode);
    assign reserved = accept && is_reserved(opcode);
    assign consume  = out_valid && out_ready;

    and_gate #(.WIDTH(WIDTH)) u_and (
        .a (acc_p1),
        .b (b),
        .y (and_y)
    );

    nand_gate #(.WIDTH(WIDTH)) u_nand (
        .a (acc_p1),
        .b (b),
        .y (nand_y)
    );

    always_comb begin
        next_acc = acc_p1;
        case (opcode)
            OP_LOAD:  next_acc = b;
            OP_AND:   next_acc = and_y;
            OP_NAND:  next_acc = nand_y;
            OP_CLEAR: next_acc = '0;
            default:  next_acc = acc_p1;
        endcase
    end

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .value (next_acc),
        .zero  (zero_d),
        .neg   (neg_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // In FULL an accept implies out_ready, so any accept there also consumes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (commit) state_d = ST_FULL;
            ST_FULL: begin
                if (commit)       state_d = ST_FULL;
                else if (consume) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = (state_q == ST_EMPTY) || out_ready;
    end

    // ---- stage p1: accumulator, flags and error pulse ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p1 <= '0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= reserved;
            if (commit) begin
                acc_p1 <= next_acc;
                zero   <= zero_d;
                neg    <= neg_d;
            end
        end
    end

    assign result = acc_p1;

`ifdef ALU_ACC_OP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (commit) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_acc_stage.sv
// Directed bench for alu_acc_stage; the op_count wrap test is built only with ALU_ACC_OP_COUNT_EN.
module tb_alu_acc_stage;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             err;
`ifdef ALU_ACC_OP_COUNT_EN
    logic [CNT_WIDTH-1:0] op_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_acc_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .err       (err)
`ifdef ALU_ACC_OP_COUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] bv);
        in_valid = v;
        opcode   = op;
        b        = bv;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0000);
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    {16'd0, result},    32'h0000);
        check("rst_zero",      {31'd0, zero},      32'd1);
        check("rst_neg",       {31'd0, neg},       32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
`ifdef ALU_ACC_OP_COUNT_EN
        check("rst_op_count",  {28'd0, op_count},  32'd0);
`endif

        // LOAD, AND, NAND back to back
        rst_n = 1'b1;
        drive(1'b1, 3'd1, 16'hF0F0);
        step();
        check("load_result",    {16'd0, result},    32'hF0F0);
        check("load_neg",       {31'd0, neg},       32'd1);
        check("load_zero",      {31'd0, zero},      32'd0);
        check("load_out_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 3'd2, 16'h0FF0);
        step();
        check("and_result", {16'd0, result}, 32'h00F0);
        check("and_neg",    {31'd0, neg},    32'd0);
        drive(1'b1, 3'd3, 16'h00F0);
        step();
        check("nand_result", {16'd0, result}, 32'hFF0F);
        check("nand_neg",    {31'd0, neg},    32'd1);

        // Back-pressure: 1234 held while a pending LOAD 5555 waits
        drive(1'b1, 3'd1, 16'h1234);
        step();
        check("load2_result", {16'd0, result}, 32'h1234);
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h5555);
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_result", {16'd0, result},    32'h1234);
            check("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_commit_result", {16'd0, result},    32'h5555);
        check("bp_commit_valid",  {31'd0, out_valid}, 32'd1);

        // CLEAR
        drive(1'b1, 3'd4, 16'hFFFF);
        step();
        check("clear_result", {16'd0, result}, 32'h0000);
        check("clear_zero",   {31'd0, zero},   32'd1);

        // Reserved opcode: err pulse, acc kept, output emptied by the consume
        drive(1'b1, 3'd1, 16'h00FF);
        step();
        check("load3_result", {16'd0, result}, 32'h00FF);
        drive(1'b1, 3'd6, 16'h1111);
        step();
        check("rsv_err",       {31'd0, err},       32'd1);
        check("rsv_out_valid", {31'd0, out_valid}, 32'd0);
        check("rsv_result",    {16'd0, result},    32'h00FF);
        drive(1'b1, 3'd0, 16'h2222);
        step();
        check("rsv_err_drop",  {31'd0, err},       32'd0);
        check("nop_out_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 3'd2, 16'h0F0F);
        step();
        check("acc_kept_and", {16'd0, result},    32'h000F);
        check("acc_kept_vld", {31'd0, out_valid}, 32'd1);

        // Reset while FULL holding ABCD
        drive(1'b1, 3'd1, 16'hABCD);
        step();
        check("abcd_result", {16'd0, result}, 32'hABCD);
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0000);
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result",    {16'd0, result},    32'h0000);
        check("midrst_zero",      {31'd0, zero},      32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;

`ifdef ALU_ACC_OP_COUNT_EN
        // 17 committing ops with NOPs and a reserved op between them: 17 mod 16 = 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'd1, 16'(i));
            step();
            drive(1'b1, (i == 5) ? 3'd7 : 3'd0, 16'h0000);
            step();
        end
        drive(1'b0, 3'd0, 16'h0000);
        step();
        check("op_count_wrap", {28'd0, op_count}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_acc_stage.md
Name: alu_acc_stage

Overview:
- Registered accumulator stage directly downstream of the 16-bit logic units (and_gate, nand_gate).
- Consumes one opcode + operand per accepted transaction. Combines the operand with the held accumulator through those units and commits the result.
- Presents the result and status flags to the next stage over a valid/ready handshake.
- Adds the clocked, back-pressurable boundary the combinational logic units lack.

Parameters:
- WIDTH, 16, datapath width of operand, accumulator and result.
- CNT_WIDTH, 16, width of transaction counter (used only with optional feature).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  opcode/operand valid.
- in_ready  output  1  stage can accept a transaction this cycle.
- opcode  input  3  0 NOP, 1 LOAD, 2 AND, 3 NAND, 4 CLEAR, 5-7 reserved.
- b  input  WIDTH  operand.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  accumulator value after the accepted op.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- err  output  1  one-cycle pulse: reserved opcode accepted.
- op_count  output  CNT_WIDTH  committed-op count (present only with ALU_ACC_OP_COUNT_EN).

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous, active-low. Sampled only at the rising edge of clk.
- Reset (rst_n=0 at edge): acc=0, out_valid=0, result=0, zero=1, neg=0, err=0, op_count=0, state=EMPTY.
- Reset mid-transaction discards the held result, with no output handshake.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- FSM, 2 states:
  - EMPTY: out_valid=0, in_ready=1. Accept of a committing op -> FULL.
  - FULL: out_valid=1, in_ready=out_ready.
  - FULL, consume without accept -> EMPTY.
  - FULL, consume with simultaneous accept of a committing op -> FULL with the new result. This gives full throughput of 1 op/cycle.
- Committing ops: LOAD acc=b; AND acc=acc&b; NAND acc=~(acc&b); CLEAR acc=0.
  - AND and NAND take acc as operand a via the and_gate/nand_gate instances.
- Latency: result of the op accepted at edge N is visible on result/out_valid after edge N (one cycle).
- Result, zero and neg are registered together. They hold stable while out_valid && !out_ready.
- NOP accepted: acc and output registers unchanged, no new out_valid. In EMPTY it remains EMPTY. Counter unchanged.
- Reserved opcode accepted:
  - err=1 for exactly the next cycle. acc unchanged, no result produced.
  - A simultaneous consume still empties the output.
- Back-to-back ops chain on the updated acc; the data dependency resolves within the cycle.
- Operand widths are all WIDTH; no carry or overflow exists for logic ops.
- Inputs other than in_valid are ignored when in_ready=0.

Optional Feature:
- Macro: ALU_ACC_OP_COUNT_EN.
- Defined: op_count port exists.
  - Increments by 1 on every accepted committing op (LOAD/AND/NAND/CLEAR). NOP and reserved do not count.
  - Wraps from 2^CNT_WIDTH-1 to 0. Resets to 0.
- Undefined: port and counter logic absent; all other behaviour identical.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_NOP=3'd0, OP_LOAD=3'd1, OP_AND=3'd2, OP_NAND=3'd3, OP_CLEAR=3'd4.
  - State encodings ST_EMPTY=1'b0, ST_FULL=1'b1.
  - Default WIDTH=16.
- Reuse existing and_gate and nand_gate as combinational sub-instances.
- One new sub-module is natural: alu_flag_gen (combinational zero/neg from next-acc value, registered in the parent).

Test Plan:
- Reset then LOAD b=16'hF0F0, out_ready=1 -> next cycle result=F0F0, neg=1, zero=0, out_valid=1.
- From F0F0, AND b=16'h0FF0 -> result=00F0. Then NAND b=16'h00F0 -> result=FF0F, neg=1.
- LOAD 16'h1234 with out_ready=0 for 3 cycles -> result holds 1234, in_ready=0, a second LOAD is not accepted. Raise out_ready -> pending op accepted same cycle and committed next.
- CLEAR -> result=0000, zero=1. Opcode 6 -> err pulses 1 cycle, acc unchanged, out_valid not newly set.
- Assert rst_n=0 while FULL holding ABCD -> next edge out_valid=0, result=0, zero=1.
- With ALU_ACC_OP_COUNT_EN and CNT_WIDTH=4: 17 committing ops interleaved with NOPs -> op_count=1 (wrapped). Without macro -> build elaborates with no op_count port.
